buffered_fork: RTL and testbench
================================

// Module: buffered_fork
// PURPOSE
//  Parametrised successor to the basic fork: replicates each input token to
//  NumOutputs consumers, with a private Depth-entry FIFO per output channel.
//  A slow consumer stalls the producer only when its own FIFO is full. The
//  other channels keep draining independently.
//  Sits between one valid/bp producer and N valid/bp consumers wherever a
//  value fans out to pipelines of unequal latency.
// PARAMETERS
//  Width       8  data bits per token (>=1)
//  NumOutputs  4  number of output channels (>=1)
//  Depth       2  entries per channel FIFO (>=1, need not be a power of 2)
// PORTS
//  clk         in   1                 clock, all state on rising edge
//  resetn      in   1                 synchronous active-low reset
//  din         in   Width             input token data
//  din_valid   in   1                 input token present
//  din_bp      out  1                 backpressure to producer (1 = stall)
//  dout        out  NumOutputs*Width  channel i data at dout[i*Width +: Width]
//  dout_valid  out  NumOutputs        per-channel token present
//  dout_bp     in   NumOutputs        per-channel backpressure from consumer
// BEHAVIOUR
//  - Handshake: a transfer occurs on any edge where valid=1 and bp=0.
//    - Producer holds din stable while din_valid=1 and din_bp=1.
//  - Per channel i: circular FIFO with rd_ptr and wr_ptr. Each pointer wraps
//    from Depth-1 to 0. Occupancy count[i] has width $clog2(Depth+1).
//  - din_bp = ~resetn | (any count[i]==Depth).
//    - Derived from registered state only.
//    - No combinational path from dout_bp to din_bp.
//    - No pop-through: a full channel blocks input even when it pops in the
//      same cycle.
//  - Input accepted (din_valid & ~din_bp): din is written into ALL channel
//    FIFOs on the same edge, so every channel receives every token.
//  - dout_valid[i] = (count[i]!=0); dout lane i = entry at rd_ptr[i]. This is a
//    registered read with no bypass.
//  - Latency: a token accepted at edge t is visible on dout_valid at edge t+1.
//  - Pop on channel i = dout_valid[i] & ~dout_bp[i].
//  - Simultaneous push and pop on channel i: count[i] is unchanged and both
//    pointers advance.
//  - Throughput:
//    - Depth>=2 sustains 1 token/cycle when no consumer stalls.
//    - Depth=1 sustains 1 token every 2 cycles.
//  - Per-channel order matches input order. Channels are never reordered
//    relative to themselves.
//  - Reset (resetn=0 on an edge):
//    - All counts and pointers are cleared to 0.
//    - Buffered tokens are discarded, including tokens present when reset
//      arrives mid-operation.
//  - Output values:
//    - dout_valid is 0 from the first edge with resetn=0.
//    - din_bp is 1 while resetn=0 and 0 on the first cycle after release.
//    - dout data is don't-care while dout_valid=0. FIFO storage is not reset.
//    - No token offered during reset is accepted.
// TESTING
//  1. W=8,N=4,D=2, all dout_bp=0, push 0xA5 -> next cycle dout_valid=4'hF,
//     every lane 0xA5, popped. Following cycle dout_valid=0.
//  2. Hold dout_bp[2]=1, push 0x01,0x02 back-to-back -> din_bp=1 after the 2nd
//     accept. Lanes 0,1,3 drain 0x01,0x02. 0x03 stalls until lane 2 pops.
//  3. Push 0x10..0x17 with random per-lane dout_bp -> each lane emits exactly
//     0x10..0x17 in order. Exercises pointer wrap; no duplication or loss.
//  4. Producer stalled (din_bp=1, din_valid=1) for 5 cycles -> token written
//     exactly once, on the release edge.
//  5. Assert resetn=0 for 1 cycle with 2 tokens buffered per lane ->
//     dout_valid=0 next cycle and din_bp=1 during reset. din_bp=0 after
//     release; no stale tokens reappear.
//  6. D=1, continuous push, no bp -> 1 token per 2 cycles. Same run with D=2
//     -> 1 token per cycle.

Source files
------------

// File: rtl/buffered_fork_if.sv
`default_nettype none
// ============================================================================
// Module      : buffered_fork_if
// Description : Producer-side and consumer-side handshake bundle for buffered_fork.
// Revision    : 1.0 - initial release
// ============================================================================
interface buffered_fork_if #(
    parameter int Width      = 8,
    parameter int NumOutputs = 4
);
    logic [Width-1:0]            din;
    logic                        din_valid;
    logic                        din_bp;
    logic [NumOutputs*Width-1:0] dout;
    logic [NumOutputs-1:0]       dout_valid;
    logic [NumOutputs-1:0]       dout_bp;

    // master: the environment (producer + consumers); slave: the fork itself
    modport master (
        output din, din_valid, dout_bp,
        input  din_bp, dout, dout_valid
    );
    modport slave (
        input  din, din_valid, dout_bp,
        output din_bp, dout, dout_valid
    );
endinterface
`default_nettype wire

// File: rtl/buffered_fork.sv
`default_nettype none
// ============================================================================
// Module      : buffered_fork
// Description : Replicates each input token to NumOutputs channels, each with
//               its own Depth-entry circular FIFO.
// Revision    : 1.0 - initial release
// ============================================================================
module buffered_fork #(
    parameter int Width      = 8,
    parameter int NumOutputs = 4,
    parameter int Depth      = 2
) (
    input  logic           clk,
    input  logic           resetn,
    buffered_fork_if.slave bus
);
    localparam int CNT_W = $clog2(Depth + 1);
    localparam int PTR_W = (Depth > 1) ? $clog2(Depth) : 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(Depth);
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(Depth - 1);

    logic [NumOutputs-1:0] full;
    logic                  din_bp;
    logic                  accept;

    // Backpressure comes from registered occupancy only, so a full channel
    // blocks input even in a cycle where it is also popping.
    assign din_bp     = ~resetn | (|full);
    assign bus.din_bp = din_bp;
    assign accept     = bus.din_valid & ~din_bp;

    for (genvar i = 0; i < NumOutputs; i++) begin : g_chan
        logic [Width-1:0] mem_q [Depth];
        logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
        logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
        logic [CNT_W-1:0] count_q,  count_d;
        logic             pop;

        assign pop = (count_q != '0) & ~bus.dout_bp[i];

        always_comb begin
            rd_ptr_d = rd_ptr_q;
            wr_ptr_d = wr_ptr_q;
            count_d  = count_q;
            if (accept) begin
                wr_ptr_d = (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_d = (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + 1'b1;
            end
            if (accept && !pop) begin
                count_d = count_q + 1'b1;
            end else if (!accept && pop) begin
                count_d = count_q - 1'b1;
            end
        end

        always_ff @(posedge clk) begin
            if (!resetn) begin
                rd_ptr_q <= '0;
                wr_ptr_q <= '0;
                count_q  <= '0;
            end else begin
                rd_ptr_q <= rd_ptr_d;
                wr_ptr_q <= wr_ptr_d;
                count_q  <= count_d;
            end
        end

        // Storage is deliberately left unreset; occupancy alone qualifies it.
        always_ff @(posedge clk) begin
            if (accept) begin
                mem_q[wr_ptr_q] <= bus.din;
            end
        end

        assign full[i]                     = (count_q == FULL_CNT);
        assign bus.dout_valid[i]           = (count_q != '0);
        assign bus.dout[i*Width +: Width]  = mem_q[rd_ptr_q];
    end

endmodule
`default_nettype wire

// File: tb/tb_buffered_fork.sv
`default_nettype none
// ============================================================================
// Module      : tb_buffered_fork
// Description : Directed self-checking bench for buffered_fork (D=2 and D=1).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_buffered_fork;
    logic clk;
    logic resetn;
    int   checks;
    int   passed;

    buffered_fork_if #(.Width(8), .NumOutputs(4)) bus0 ();
    buffered_fork_if #(.Width(8), .NumOutputs(4)) bus1 ();

    buffered_fork #(.Width(8), .NumOutputs(4), .Depth(2)) u_dut_d2 (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus0.slave)
    );

    buffered_fork #(.Width(8), .NumOutputs(4), .Depth(1)) u_dut_d1 (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus1.slave)
    );

    logic [7:0] lane0 [4];
    logic [7:0] lane1 [4];
    for (genvar g = 0; g < 4; g++) begin : g_lane
        assign lane0[g] = bus0.dout[g*8 +: 8];
        assign lane1[g] = bus1.dout[g*8 +: 8];
    end

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got timeout want completion");
        $fatal(1, "watchdog");
    end

    task automatic test_reset();
        resetn = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (bus0.dout_valid !== 4'h0) $display("FAIL reset_valid: got %h want 0", bus0.dout_valid); else passed++;
        checks++; if (bus0.din_bp !== 1'b1) $display("FAIL reset_bp: got %b want 1", bus0.din_bp); else passed++;
        resetn = 1'b1;
        @(negedge clk);
        checks++; if (bus0.din_bp !== 1'b0) $display("FAIL release_bp: got %b want 0", bus0.din_bp); else passed++;
        checks++; if (bus1.din_bp !== 1'b0) $display("FAIL release_bp_d1: got %b want 0", bus1.din_bp); else passed++;
        checks++; if (bus0.dout_valid !== 4'h0) $display("FAIL release_valid: got %h want 0", bus0.dout_valid); else passed++;
    endtask

    task automatic test_single();
        bus0.din = 8'hA5; bus0.din_valid = 1'b1; bus0.dout_bp = 4'h0;
        @(negedge clk);
        bus0.din_valid = 1'b0;
        checks++; if (bus0.dout_valid !== 4'hF) $display("FAIL single_valid: got %h want f", bus0.dout_valid); else passed++;
        for (int i = 0; i < 4; i++) begin
            checks++; if (lane0[i] !== 8'hA5) $display("FAIL single_data lane %0d: got %h want a5", i, lane0[i]); else passed++;
        end
        @(negedge clk);
        checks++; if (bus0.dout_valid !== 4'h0) $display("FAIL single_drain: got %h want 0", bus0.dout_valid); else passed++;
    endtask

    task automatic test_lane_stall();
        bus0.dout_bp = 4'b0100;
        bus0.din = 8'h01; bus0.din_valid = 1'b1;
        @(negedge clk);
        checks++; if (bus0.din_bp !== 1'b0) $display("FAIL stall_bp_first: got %b want 0", bus0.din_bp); else passed++;
        bus0.din = 8'h02;
        @(negedge clk);
        checks++; if (bus0.din_bp !== 1'b1) $display("FAIL stall_bp_full: got %b want 1", bus0.din_bp); else passed++;
        checks++; if (lane0[0] !== 8'h02) $display("FAIL stall_lane0: got %h want 02", lane0[0]); else passed++;
        checks++; if (lane0[2] !== 8'h01) $display("FAIL stall_lane2_head: got %h want 01", lane0[2]); else passed++;
        bus0.din = 8'h03;
        @(negedge clk);
        checks++; if (bus0.dout_valid !== 4'b0100) $display("FAIL stall_valid: got %h want 4", bus0.dout_valid); else passed++;
        checks++; if (bus0.din_bp !== 1'b1) $display("FAIL stall_bp_hold: got %b want 1", bus0.din_bp); else passed++;
        bus0.dout_bp = 4'h0;
        @(negedge clk);
        checks++; if (bus0.din_bp !== 1'b0) $display("FAIL stall_bp_release: got %b want 0", bus0.din_bp); else passed++;
        checks++; if (lane0[2] !== 8'h02) $display("FAIL stall_lane2_second: got %h want 02", lane0[2]); else passed++;
        @(negedge clk);
        bus0.din_valid = 1'b0;
        checks++; if (bus0.dout_valid !== 4'hF) $display("FAIL stall_third_valid: got %h want f", bus0.dout_valid); else passed++;
        checks++; if (lane0[2] !== 8'h03) $display("FAIL stall_third_lane2: got %h want 03", lane0[2]); else passed++;
        @(negedge clk);
        checks++; if (bus0.dout_valid !== 4'h0) $display("FAIL stall_empty: got %h want 0", bus0.dout_valid); else passed++;
    endtask

    task automatic test_random_order();
        int sent;
        int got [4];
        int cyc;
        sent = 0;
        for (int i = 0; i < 4; i++) got[i] = 0;
        cyc = 0;
        while (((got[0] + got[1] + got[2] + got[3]) < 32) && (cyc < 300)) begin
            bus0.dout_bp   = 4'($urandom_range(0, 15));
            bus0.din_valid = (sent < 8);
            bus0.din       = 8'(8'h10 + sent);
            if (bus0.din_valid && !bus0.din_bp) sent++;
            for (int i = 0; i < 4; i++) begin
                if (bus0.dout_valid[i] && !bus0.dout_bp[i]) begin
                    checks++;
                    if (got[i] >= 8)
                        $display("FAIL order_dup lane %0d: got extra %h want none", i, lane0[i]);
                    else if (lane0[i] !== 8'(8'h10 + got[i]))
                        $display("FAIL order_data lane %0d: got %h want %h", i, lane0[i], 8'(8'h10 + got[i]));
                    else passed++;
                    got[i]++;
                end
            end
            @(negedge clk);
            cyc++;
        end
        bus0.din_valid = 1'b0;
        bus0.dout_bp   = 4'h0;
        for (int i = 0; i < 4; i++) begin
            checks++; if (got[i] != 8) $display("FAIL order_count lane %0d: got %0d want 8", i, got[i]); else passed++;
        end
        @(negedge clk);
        checks++; if (bus0.dout_valid !== 4'h0) $display("FAIL order_leftover: got %h want 0", bus0.dout_valid); else passed++;
    endtask

    task automatic test_producer_stall();
        bus0.dout_bp = 4'b0010;
        bus0.din = 8'hAA; bus0.din_valid = 1'b1;
        @(negedge clk);
        bus0.din = 8'hBB;
        @(negedge clk);
        bus0.din = 8'hCC;
        checks++; if (bus0.din_bp !== 1'b1) $display("FAIL pstall_bp_start: got %b want 1", bus0.din_bp); else passed++;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            checks++; if (bus0.din_bp !== 1'b1) $display("FAIL pstall_bp cycle %0d: got %b want 1", k, bus0.din_bp); else passed++;
            checks++; if (bus0.dout_valid !== 4'b0010) $display("FAIL pstall_valid cycle %0d: got %h want 2", k, bus0.dout_valid); else passed++;
        end
        bus0.dout_bp = 4'h0;
        @(negedge clk);
        checks++; if (lane0[1] !== 8'hBB) $display("FAIL pstall_lane1: got %h want bb", lane0[1]); else passed++;
        checks++; if (bus0.dout_valid !== 4'b0010) $display("FAIL pstall_pre_release: got %h want 2", bus0.dout_valid); else passed++;
        @(negedge clk);
        bus0.din_valid = 1'b0;
        checks++; if (bus0.dout_valid !== 4'hF) $display("FAIL pstall_release_valid: got %h want f", bus0.dout_valid); else passed++;
        checks++; if (lane0[3] !== 8'hCC) $display("FAIL pstall_release_data: got %h want cc", lane0[3]); else passed++;
        @(negedge clk);
        checks++; if (bus0.dout_valid !== 4'h0) $display("FAIL pstall_once: got %h want 0", bus0.dout_valid); else passed++;
    endtask

    task automatic test_reset_mid();
        bus0.dout_bp = 4'hF;
        bus0.din = 8'h21; bus0.din_valid = 1'b1;
        @(negedge clk);
        bus0.din = 8'h22;
        @(negedge clk);
        bus0.din = 8'h99;
        checks++; if (bus0.dout_valid !== 4'hF) $display("FAIL rmid_pre_valid: got %h want f", bus0.dout_valid); else passed++;
        resetn = 1'b0;
        @(negedge clk);
        checks++; if (bus0.dout_valid !== 4'h0) $display("FAIL rmid_valid: got %h want 0", bus0.dout_valid); else passed++;
        checks++; if (bus0.din_bp !== 1'b1) $display("FAIL rmid_bp: got %b want 1", bus0.din_bp); else passed++;
        resetn = 1'b1;
        bus0.din_valid = 1'b0;
        bus0.dout_bp = 4'h0;
        @(negedge clk);
        checks++; if (bus0.din_bp !== 1'b0) $display("FAIL rmid_release_bp: got %b want 0", bus0.din_bp); else passed++;
        checks++; if (bus0.dout_valid !== 4'h0) $display("FAIL rmid_stale: got %h want 0", bus0.dout_valid); else passed++;
        bus0.din = 8'h33; bus0.din_valid = 1'b1;
        @(negedge clk);
        bus0.din_valid = 1'b0;
        checks++; if (lane0[0] !== 8'h33) $display("FAIL rmid_fresh: got %h want 33", lane0[0]); else passed++;
        @(negedge clk);
        checks++; if (bus0.dout_valid !== 4'h0) $display("FAIL rmid_drain: got %h want 0", bus0.dout_valid); else passed++;
    endtask

    task automatic test_throughput();
        int acc0, acc1, nxt0, nxt1;
        acc0 = 0; acc1 = 0; nxt0 = 0; nxt1 = 0;
        bus0.dout_bp = 4'h0; bus1.dout_bp = 4'h0;
        for (int c = 0; c < 10; c++) begin
            bus0.din = 8'(8'h40 + acc0); bus0.din_valid = 1'b1;
            bus1.din = 8'(8'h60 + acc1); bus1.din_valid = 1'b1;
            if (bus0.dout_valid[3]) begin
                checks++; if (lane0[3] !== 8'(8'h40 + nxt0)) $display("FAIL tput_d2_data: got %h want %h", lane0[3], 8'(8'h40 + nxt0)); else passed++;
                nxt0++;
            end
            if (bus1.dout_valid[3]) begin
                checks++; if (lane1[3] !== 8'(8'h60 + nxt1)) $display("FAIL tput_d1_data: got %h want %h", lane1[3], 8'(8'h60 + nxt1)); else passed++;
                nxt1++;
            end
            if (!bus0.din_bp) acc0++;
            if (!bus1.din_bp) acc1++;
            @(negedge clk);
        end
        bus0.din_valid = 1'b0; bus1.din_valid = 1'b0;
        checks++; if (acc0 != 10) $display("FAIL tput_d2: got %0d want 10", acc0); else passed++;
        checks++; if (acc1 != 5) $display("FAIL tput_d1: got %0d want 5", acc1); else passed++;
        repeat (3) @(negedge clk);
        checks++; if (bus1.dout_valid !== 4'h0) $display("FAIL tput_d1_drain: got %h want 0", bus1.dout_valid); else passed++;
    endtask

    initial begin
        clk = 1'b0; resetn = 1'b0;
        checks = 0; passed = 0;
        bus0.din = '0; bus0.din_valid = 1'b0; bus0.dout_bp = '0;
        bus1.din = '0; bus1.din_valid = 1'b0; bus1.dout_bp = '0;
        test_reset();
        test_single();
        test_lane_stall();
        test_random_order();
        test_producer_stall();
        test_reset_mid();
        test_throughput();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
`default_nettype wire
